// File: rtl/seven_seg_scan_ctrl_if.sv
// Bundle between the voltage calculator (data side) and the front-panel
// display pins, shared by the scan controller and whatever drives it.
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digit_data;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    blank_lz;
  logic                    hold;
  logic                    upd_req;
  logic [NUM_DIGITS-1:0]   en;
  logic [6:0]              svn_conf;
  logic                    DP;

  modport master (
    output digit_data, dp_mask, blank_lz, hold,
    input  upd_req, en, svn_conf, DP
  );

  modport slave (
    input  digit_data, dp_mask, blank_lz, hold,
    output upd_req, en, svn_conf, DP
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed active-low 7-segment driver: slot scanning with anti-ghost
// blanking, periodic data snapshots, hold mode and leading-zero blanking.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 48000,
  parameter int BLANK_CYC  = 600,
  parameter int UPDATE_DIV = 6000000
) (
  input  logic                  clk,
  input  logic                  rst,
  seven_seg_scan_ctrl_if.slave  bus
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int UPD_W  = $clog2(UPDATE_DIV);
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0] BLANK_END = SCAN_W'(BLANK_CYC);
  localparam logic [UPD_W-1:0]  UPD_LAST  = UPD_W'(UPDATE_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [SCAN_W-1:0]       scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]        idx_q,      idx_d;
  logic [UPD_W-1:0]        upd_cnt_q,  upd_cnt_d;
  logic [4*NUM_DIGITS-1:0] data_snap_q, data_snap_d;
  logic [NUM_DIGITS-1:0]   dp_snap_q,  dp_snap_d;
  logic                    upd_req_q,  upd_req_d;
  logic [NUM_DIGITS-1:0]   en_q,       en_d;
  logic [6:0]              svn_q,      svn_d;
  logic                    dp_q,       dp_d;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_digit;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      4'hF: hex_to_seg = 7'h0E;
    endcase
  endfunction

  // Scan slot / digit index and snapshot timing.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    scan_cnt_d  = scan_cnt_q + 1'b1;
    idx_d       = idx_q;
    upd_cnt_d   = upd_cnt_q + 1'b1;
    data_snap_d = data_snap_q;
    dp_snap_d   = dp_snap_q;
    upd_req_d   = 1'b0;

    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    if (upd_cnt_q == UPD_LAST) begin
      upd_cnt_d = '0;
      if (!bus.hold) begin
        data_snap_d = bus.digit_data;
        dp_snap_d   = bus.dp_mask;
        upd_req_d   = 1'b1;
      end
    end
  end

  // Pin values for the next cycle; blank_lz is used live, the data is not.
  always_comb begin : pin_decode
    logic lz_run;
    lz_run   = bus.blank_lz;
    lz_blank = '0;
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      lz_run      = lz_run & (data_snap_q[4*i +: 4] == 4'h0) & ~dp_snap_q[i];
      lz_blank[i] = lz_run;
    end

    cur_digit = data_snap_q[{idx_q, 2'b00} +: 4];
    en_d      = '1;
    svn_d     = 7'h7F;
    dp_d      = 1'b1;

    if (scan_cnt_q >= BLANK_END) begin
      en_d[idx_q] = 1'b0;
      svn_d       = lz_blank[idx_q] ? 7'h7F : hex_to_seg(cur_digit);
      dp_d        = ~dp_snap_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      upd_cnt_q   <= '0;
      // NOTE: the snapshot registers are cleared too, so a fresh panel shows
      // defined (zero) data until the first snapshot instead of junk.
      data_snap_q <= '0;
      dp_snap_q   <= '0;
      upd_req_q   <= 1'b0;
      en_q        <= '1;
      svn_q       <= 7'h7F;
      dp_q        <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      upd_cnt_q   <= upd_cnt_d;
      data_snap_q <= data_snap_d;
      dp_snap_q   <= dp_snap_d;
      upd_req_q   <= upd_req_d;
      en_q        <= en_d;
      svn_q       <= svn_d;
      dp_q        <= dp_d;
    end
  end

  assign bus.upd_req  = upd_req_q;
  assign bus.en       = en_q;
  assign bus.svn_conf = svn_q;
  assign bus.DP       = dp_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl: a cycle-count reference model
// queues the expected pin state per edge, a monitor compares on the falling edge.
module tb_seven_seg_scan_ctrl;
  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int UD = 64;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [ND-1:0] en;
    logic [6:0]    svn;
    logic          dp;
    logic          upd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .UPDATE_DIV(UD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t          sb_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            n = 0;           // clock edges since reset release
  logic [4*ND-1:0] m_data = '0;
  logic [ND-1:0]   m_dp = '0;

  // Reference model: position in the scan follows directly from elapsed cycles.
  task automatic model_step();
    exp_t e;
    int   idx, slot;
    bit   lz;
    e.en = '1; e.svn = 7'h7F; e.dp = 1'b1; e.upd = 1'b0;
    if (rst) begin
      n = 0; m_data = '0; m_dp = '0;
    end else begin
      slot  = n % SD;
      idx   = (n / SD) % ND;
      e.upd = ((n % UD) == UD - 1) && !bus.hold;
      if (slot >= BC) begin
        e.en[idx] = 1'b0;
        lz = bus.blank_lz && (idx < ND - 1);
        for (int k = 0; k <= idx; k++)
          if (m_data[4*k +: 4] != 4'h0 || m_dp[k]) lz = 1'b0;
        e.svn = lz ? 7'h7F : SEG_TAB[m_data[4*idx +: 4]];
        e.dp  = ~m_dp[idx];
      end
      if (e.upd) begin
        m_data = bus.digit_data;
        m_dp   = bus.dp_mask;
      end
      n++;
    end
    sb_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: the pins are valid every cycle, one expected entry per edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL sb_empty @%0t: no expected entry queued", $time);
    end else begin
      e = sb_q.pop_front();
      if (bus.en !== e.en || bus.svn_conf !== e.svn || bus.DP !== e.dp ||
          bus.upd_req !== e.upd) begin
        miscompares++;
        $display("FAIL pins @%0t n=%0d: got en=%b svn=%h dp=%b upd=%b, want en=%b svn=%h dp=%b upd=%b",
                 $time, n, bus.en, bus.svn_conf, bus.DP, bus.upd_req,
                 e.en, e.svn, e.dp, e.upd);
      end
    end
  end

  task automatic run(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic randomize_inputs();
    logic [4*ND-1:0] d;
    d = 16'($urandom);
    if ($urandom_range(0, 2) == 0) begin
      int z;
      z = $urandom_range(1, ND);
      for (int k = 0; k < z; k++) d[4*k +: 4] = 4'h0;
    end
    bus.digit_data = d;
    bus.dp_mask    = ($urandom_range(0, 1) == 0) ? '0 : ND'($urandom);
    bus.blank_lz   = 1'($urandom);
    bus.hold       = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    bus.digit_data = 16'h3210;
    bus.dp_mask    = 4'b0001;
    bus.blank_lz   = 1'b0;
    bus.hold       = 1'b0;
    rst = 1'b1;
    run(3);
    rst = 1'b0;

    // Reset state, first snapshot at cycle 64, basic decode and scan wrap.
    run(140);

    // Leading-zero blanking.
    bus.digit_data = 16'h5000;
    bus.dp_mask    = 4'b0000;
    bus.blank_lz   = 1'b1;
    run(80);

    // Hold across an update wrap, then release.
    bus.hold       = 1'b1;
    bus.digit_data = 16'hABCD;
    bus.dp_mask    = 4'b1010;
    run(80);
    bus.hold = 1'b0;
    run(80);

    // Reset in the middle of the idx2 slot.
    for (int w = 0; w < 64 && (n % (SD * ND)) != 2 * SD + 3; w++) @(negedge clk);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(40);

    // Randomized traffic with occasional resets.
    for (int ep = 0; ep < 40; ep++) begin
      randomize_inputs();
      run($urandom_range(5, 90));
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        run($urandom_range(1, 2));
        rst = 1'b0;
      end
    end
    bus.hold = 1'b0;
    run(130);

    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
